// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct values, ALU operation codes and the decoded control bundle
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } aluop_t;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        logic   branch;
        logic   illegal;
        aluop_t aluop;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: combinational instruction decode into control, immediate, destination and operand fields
module control_decode
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [REGW-1:0] wreg,
    output logic [REGW-1:0] rs,
    output logic [REGW-1:0] rt,
    output logic            uses_rt
);

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] sext;
    logic [XLEN-1:0] zext;
    logic            writes;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign rs    = REGW'(instr[25:21]);
    assign rt    = REGW'(instr[20:16]);
    assign rd    = REGW'(instr[15:11]);
    assign sext  = {{(XLEN-16){instr[15]}}, instr[15:0]};
    assign zext  = {{(XLEN-16){1'b0}}, instr[15:0]};

    // Unknown encodings fall through to the defaults: no side effects, illegal flagged
    always_comb begin
        ctrl    = '0;
        imm     = '0;
        wreg    = '0;
        uses_rt = 1'b0;
        writes  = 1'b0;
        case (op)
            OP_RTYPE: begin
                writes  = 1'b1;
                uses_rt = 1'b1;
                wreg    = rd;
                case (funct)
                    FN_ADD:  ctrl.aluop = ALU_ADD;
                    FN_SUB:  ctrl.aluop = ALU_SUB;
                    FN_AND:  ctrl.aluop = ALU_AND;
                    FN_OR:   ctrl.aluop = ALU_OR;
                    FN_SLT:  ctrl.aluop = ALU_SLT;
                    default: begin
                        writes       = 1'b0;
                        uses_rt      = 1'b0;
                        wreg         = '0;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                writes      = 1'b1;
                wreg        = rt;
                ctrl.alusrc = 1'b1;
                imm         = sext;
            end
            OP_ANDI: begin
                writes      = 1'b1;
                wreg        = rt;
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALU_AND;
                imm         = zext;
            end
            OP_ORI: begin
                writes      = 1'b1;
                wreg        = rt;
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALU_OR;
                imm         = zext;
            end
            OP_LW: begin
                writes        = 1'b1;
                wreg          = rt;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm           = sext;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm           = sext;
            end
            OP_BEQ: begin
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.aluop  = ALU_SUB;
                imm         = sext;
            end
            default: ctrl.illegal = 1'b1;
        endcase
        ctrl.regwrite = writes && wreg != '0;
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS ID stage with handshake, load-use stall, flush and a single ID/EX slot
module decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [REGW-1:0] rf_rs,
    output logic [REGW-1:0] rf_rt,
    input  logic [XLEN-1:0] rf_a,
    input  logic [XLEN-1:0] rf_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [REGW-1:0] out_wreg,
    output logic [2:0]      out_aluop,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_memtoreg,
    output logic            out_alusrc,
    output logic            out_branch,
    output logic            out_illegal
);

    ctrl_t           ctrl;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] wreg;
    logic            uses_rt;
    logic            hazard;
    logic            accept;

    control_decode #(.XLEN(XLEN), .REGW(REGW)) u_dec (
        .instr   (in_instr[31:0]),
        .ctrl    (ctrl),
        .imm     (imm),
        .wreg    (wreg),
        .rs      (rf_rs),
        .rt      (rf_rt),
        .uses_rt (uses_rt)
    );

    // A load in the slot cannot forward yet, so a dependent consumer must wait one cycle
    assign hazard   = out_valid && ctrl_q.memread && out_wreg != '0 &&
                      (out_wreg == rf_rs || (uses_rt && out_wreg == rf_rt));
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign out_aluop    = ctrl_q.aluop;
    assign out_regwrite = ctrl_q.regwrite;
    assign out_memread  = ctrl_q.memread;
    assign out_memwrite = ctrl_q.memwrite;
    assign out_memtoreg = ctrl_q.memtoreg;
    assign out_alusrc   = ctrl_q.alusrc;
    assign out_branch   = ctrl_q.branch;
    assign out_illegal  = ctrl_q.illegal;

    // ID/EX slot: flush beats accept beats drain; otherwise the slot holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_imm   <= '0;
            out_pc    <= '0;
            out_wreg  <= '0;
            ctrl_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= rf_a;
            out_b     <= rf_b;
            out_imm   <= imm;
            out_pc    <= in_pc;
            out_wreg  <= wreg;
            ctrl_q    <= ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the MIPS pipeline, directly upstream of the register file.
- Takes fetched instructions via a valid/ready handshake and drives the register file read indices combinationally.
- Captures the returned A/B operands, the extended immediate and the decoded control into a single ID/EX output slot for the execute stage.
- Detects load-use hazards and inserts bubbles; supports a synchronous flush from branch resolution.

Parameters:
- XLEN, 32, datapath width (instruction, PC, operands).
- REGW, 5, register index width.

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  XLEN  instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard the output slot and the current input.
- rf_rs  out  REGW  equals in_instr[25:21], combinational.
- rf_rt  out  REGW  equals in_instr[20:16], combinational.
- rf_a  in  XLEN  register file read data for rf_rs.
- rf_b  in  XLEN  register file read data for rf_rt.
- out_valid  out  1  ID/EX slot holds a valid instruction.
- out_ready  in  1  execute stage consumes the slot.
- out_a, out_b  out  XLEN  latched operands.
- out_imm  out  XLEN  extended immediate.
- out_pc  out  XLEN  latched PC.
- out_wreg  out  REGW  destination register.
- out_aluop  out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT.
- out_regwrite, out_memread, out_memwrite, out_memtoreg, out_alusrc, out_branch, out_illegal  out  1 each  control bits.

Behaviour:
- Reset (rst_n=0, async): out_valid=0; every out_* data and control output is 0.
- Decode set:
  - R-type (op 0x00), funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2A.
  - I-type: addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
- Unknown op or funct: all control 0, out_illegal=1, wreg=0, aluop=ADD. The instruction still passes as a harmless bubble.
- Immediate extension:
  - Sign-extend instr[15:0] for addi, lw, sw, beq.
  - Zero-extend for andi, ori.
  - 0 for R-type.
- Destination: wreg = rd (instr[15:11]) for R-type; rt for addi/andi/ori/lw; 0 for sw/beq.
- regwrite = 1 only if the instruction writes and wreg != 0. Writes to $0 are suppressed here.
- alusrc = 1 for addi/andi/ori/lw/sw.
- aluop: SUB for beq; ADD for lw/sw/addi; AND/OR for andi/ori.
- Rt-as-source instructions: R-type, sw, beq.
- Load-use hazard (combinational): out_valid & out_memread & out_wreg!=0 & (out_wreg==rs, or out_wreg==rt when rt is a source).
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Slot update, evaluated each clock in priority order:
  1. flush=1: out_valid<=0; input dropped.
  2. Accept (in_valid & in_ready): latch rf_a, rf_b, imm, pc, decoded control; out_valid<=1.
  3. out_ready=1 and no accept (includes the hazard case): out_valid<=0, which forms the bubble.
  4. Otherwise hold all outputs stable.
- Hazard bubble: exactly one cycle per load-use pair. The next cycle the lw has left the slot, so the hazard clears and the instruction is accepted.
- Latency: 1 cycle from accept to out_valid.
- Full throughput when out_ready=1 and there are no hazards.
- Output data and control must not change while out_valid=1 and out_ready=0.
- rst_n deasserted mid-stream: the slot is empty afterwards and the in-flight instruction is lost. Fetch re-presents it.

Decomposition:
- mips_pkg:
  - opcode and funct localparams;
  - aluop encodings;
  - packed ctrl struct (regwrite, memread, memwrite, memtoreg, alusrc, branch, illegal, aluop).
- Sub-module control_decode: purely combinational. Maps instr to ctrl, imm, wreg, and the uses_rt flag. decode_stage holds the handshake, hazard logic and slot register.

Test Plan:
- Reset: rst_n=0 mid-operation -> out_valid=0 and all outputs 0 immediately, without waiting for clk.
- add $3,$1,$2 (0x00221820) with rf_a=5, rf_b=7, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, wreg=3, aluop=ADD, regwrite=1.
- addi $4,$0,-1 (0x2004FFFF) -> imm=0xFFFFFFFF, alusrc=1. ori $4,$0,0xFFFF (0x3404FFFF) -> imm=0x0000FFFF.
- lw $2,0($1) then add $3,$2,$2 -> in_ready=0 for 1 cycle, one bubble (out_valid=0), then add is accepted. sw $5,0($2) after lw $2 also stalls; addi $6,$7,1 after lw $2 does not.
- Backpressure: out_ready=0 for 3 cycles with a valid slot -> outputs stable, in_ready=0. Asserting flush in the same cycle -> out_valid=0 next edge and the input is not taken.
- Illegal op 0x3F000000 -> out_illegal=1, regwrite=memwrite=0. add to $0 (0x00220020) -> regwrite=0.
